text_stream_writer: RTL
=======================

// Module: text_stream_writer
// PURPOSE
//   Parametrised character-stream writer for the VGA text-mode character RAM. Accepts one
//   character per valid/ready handshake, writes it at the cursor, advances the cursor and
//   interprets control codes (LF, CR, BS, FF). At the bottom row it either stops (FULL mode)
//   or wraps to the top, clearing the new row first. It sits between the command/UART
//   front end and the character RAM write port.
// PARAMETERS
//   COLS       80    columns per row; COLS <= 2**COL_BITS
//   ROWS       30    rows per screen; ROWS <= 2**ROW_BITS
//   COL_BITS   8     column field width of o_address
//   ROW_BITS   5     row field width of o_address
//   ADDR_W     16    o_address width; >= ROW_BITS+COL_BITS
//   DATA_W     9     character code width
//   WRAP_MODE  0     0 = stop at end of screen; 1 = wrap to row 0 and clear that row
//   FILL_CHAR  32    code written by BS, row clear and screen clear
// PORTS
//   i_clk      in   1         system clock, all logic on rising edge
//   clean      in   1         synchronous active-high reset
//   i_valid    in   1         i_char valid
//   i_char     in   DATA_W    character or control code
//   o_ready    out  1         writer accepts i_char this cycle
//   o_address  out  ADDR_W    RAM address = {zero-extend, row, col}
//   o_data     out  DATA_W    RAM write data
//   o_we       out  1         RAM write enable, one cycle per cell
//   o_full     out  1         end of screen reached (WRAP_MODE 0 only)
//   o_busy     out  1         row or screen clear in progress
//   o_col      out  COL_BITS  current cursor column
//   o_row      out  ROW_BITS  current cursor row
// BEHAVIOUR
//   - Reset (clean=1 at edge): cursor 0,0; state READY; o_we=0, o_address=0, o_data=0,
//     o_full=0, o_busy=0. o_ready is 0 while clean is high. clean aborts any clear
//     immediately, with no further writes.
//   - States: READY, CLR_ROW, CLR_SCR, FULL. o_ready=1 in READY and FULL, 0 otherwise.
//   - A character is accepted on an edge with i_valid & o_ready. All outputs are registered.
//     A write for the accepted character appears on o_we/o_address/o_data in the next
//     cycle (latency 1), and the cursor update is visible on o_col/o_row in that same cycle.
//   - Printable (any code other than 0x08, 0x0A, 0x0C, 0x0D):
//     write at (row,col); then if col<COLS-1, col+1; else col=0 and perform row advance.
//   - LF 0x0A: no write; col=0; perform row advance.
//   - CR 0x0D: no write; col=0.
//   - BS 0x08: if col>0, col-1 and write FILL_CHAR at the new column; at col 0 it is a no-op.
//   - FF 0x0C: go to CLR_SCR; write FILL_CHAR to all ROWS*COLS cells in row-major order,
//     one cell per cycle; then cursor=0,0, o_full=0, return to READY.
//   - Row advance when row<ROWS-1: row+1.
//   - Row advance when row==ROWS-1 with WRAP_MODE 0: cursor stays at (ROWS-1,COLS-1) for
//     printable or (ROWS-1,0) for LF; o_full=1; state FULL.
//   - Row advance when row==ROWS-1 with WRAP_MODE 1: row=0, col=0; CLR_ROW writes
//     FILL_CHAR to cells (0,0)..(0,COLS-1); then READY.
//   - FULL: FF is accepted and starts CLR_SCR. All other codes are accepted and discarded
//     (o_we stays 0). o_full stays 1 until the CLR_SCR clear completes or clean.
//   - o_busy=1 exactly while in CLR_ROW/CLR_SCR; o_we=1 on every cycle of those states.
//   - o_we=0 in any cycle with no write; o_address/o_data hold their last values.
// TESTING
//   1. Reset, send 'A'(65),'B'(66) back-to-back -> writes addr 0x0000=65 and 0x0001=66 on
//      consecutive cycles; o_col=2.
//   2. Send 80 printable chars then 'Z' -> 80th write at {row0,col79}; 'Z' written at
//      {row1,col0}, i.e. addr 0x0100.
//   3. Cursor at (3,5): send BS -> write FILL_CHAR at (3,4), o_col=4. Then send CR -> o_col=0
//      with no write. Then send BS -> no write.
//   4. WRAP_MODE=0: fill all 2400 cells -> o_full=1 and o_ready=1. Send 'Q' -> no write.
//      Send FF -> o_busy for 2400 cycles, then o_full=0 and cursor 0,0.
//   5. WRAP_MODE=1: cursor at row 29, send LF -> o_ready=0 and 80 FILL writes to row 0;
//      then o_ready=1 with cursor 0,0.
//   6. Assert clean mid CLR_SCR (cycle 100) -> o_we=0 in the next cycle; cursor 0,0; state
//      READY.

Source files
------------

// File: rtl/text_stream_writer.sv
// Character-stream writer for the VGA text-mode character RAM: places characters at the
// cursor, interprets LF/CR/BS/FF, and either stops at the end of screen or wraps and clears.
module text_stream_writer #(
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROWS      = 30,
    parameter int unsigned COL_BITS  = 8,
    parameter int unsigned ROW_BITS  = 5,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 9,
    parameter int unsigned WRAP_MODE = 0,
    parameter int unsigned FILL_CHAR = 32
) (
    input  logic                i_clk,
    input  logic                clean,
    input  logic                i_valid,
    input  logic [DATA_W-1:0]   i_char,
    output logic                o_ready,
    output logic [ADDR_W-1:0]   o_address,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_we,
    output logic                o_full,
    output logic                o_busy,
    output logic [COL_BITS-1:0] o_col,
    output logic [ROW_BITS-1:0] o_row
);

    typedef enum logic [1:0] {
        S_READY,
        S_CLR_ROW,
        S_CLR_SCR,
        S_FULL
    } state_t;

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
    localparam logic [DATA_W-1:0]   FILL     = DATA_W'(FILL_CHAR);
    localparam logic [DATA_W-1:0]   CH_BS    = DATA_W'(8'h08);
    localparam logic [DATA_W-1:0]   CH_LF    = DATA_W'(8'h0A);
    localparam logic [DATA_W-1:0]   CH_FF    = DATA_W'(8'h0C);
    localparam logic [DATA_W-1:0]   CH_CR    = DATA_W'(8'h0D);

    state_t              state_q, state_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] clr_col_q, clr_col_d;
    logic [ROW_BITS-1:0] clr_row_q, clr_row_d;
    logic                clr_last_q, clr_last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                full_q, full_d;
    logic                adv, adv_print, start_scr;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_BITS-1:0] r,
                                                    input logic [COL_BITS-1:0] c);
        logic [ADDR_W-1:0] a;
        a = '0;
        a[COL_BITS +: ROW_BITS] = r;
        a[COL_BITS-1:0]         = c;
        return a;
    endfunction

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        clr_col_d  = clr_col_q;
        clr_row_d  = clr_row_q;
        clr_last_d = clr_last_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        full_d     = full_q;
        adv        = 1'b0;
        adv_print  = 1'b0;
        start_scr  = 1'b0;

        case (state_q)
            S_READY: begin
                if (i_valid) begin
                    if (i_char == CH_BS) begin
                        if (col_q != '0) begin
                            col_d  = col_q - 1'b1;
                            we_d   = 1'b1;
                            addr_d = cell_addr(row_q, col_q - 1'b1);
                            data_d = FILL;
                        end
                    end else if (i_char == CH_CR) begin
                        col_d = '0;
                    end else if (i_char == CH_LF) begin
                        adv = 1'b1;
                    end else if (i_char == CH_FF) begin
                        start_scr = 1'b1;
                    end else begin
                        we_d   = 1'b1;
                        addr_d = cell_addr(row_q, col_q);
                        data_d = i_char;
                        if (col_q != LAST_COL) begin
                            col_d = col_q + 1'b1;
                        end else begin
                            adv       = 1'b1;
                            adv_print = 1'b1;
                        end
                    end
                end
            end
            S_FULL: begin
                if (i_valid && (i_char == CH_FF)) begin
                    start_scr = 1'b1;
                end
            end
            default: begin
                // clr_last_q marks that the write just presented was the final cell
                if (clr_last_q) begin
                    state_d = S_READY;
                    if (state_q == S_CLR_SCR) begin
                        col_d  = '0;
                        row_d  = '0;
                        full_d = 1'b0;
                    end
                end else begin
                    we_d       = 1'b1;
                    addr_d     = cell_addr(clr_row_q, clr_col_q);
                    data_d     = FILL;
                    clr_last_d = (clr_col_q == LAST_COL) &&
                                 ((state_q == S_CLR_ROW) || (clr_row_q == LAST_ROW));
                    if (clr_col_q == LAST_COL) begin
                        clr_col_d = '0;
                        clr_row_d = clr_row_q + 1'b1;
                    end else begin
                        clr_col_d = clr_col_q + 1'b1;
                    end
                end
            end
        endcase

        if (adv) begin
            col_d = '0;
            if (row_q != LAST_ROW) begin
                row_d = row_q + 1'b1;
            end else if (WRAP_MODE == 0) begin
                state_d = S_FULL;
                full_d  = 1'b1;
                col_d   = adv_print ? LAST_COL : '0;
            end else begin
                // A wrapping printable owns the first CLR_ROW cycle with its own write,
                // so the fill then starts at column 0; LF issues the first fill itself.
                state_d   = S_CLR_ROW;
                row_d     = '0;
                clr_row_d = '0;
                if (adv_print) begin
                    clr_col_d  = '0;
                    clr_last_d = 1'b0;
                end else begin
                    we_d       = 1'b1;
                    addr_d     = cell_addr('0, '0);
                    data_d     = FILL;
                    clr_col_d  = (COLS > 1) ? COL_BITS'(1) : '0;
                    clr_last_d = (COLS == 1);
                end
            end
        end

        if (start_scr) begin
            state_d    = S_CLR_SCR;
            we_d       = 1'b1;
            addr_d     = cell_addr('0, '0);
            data_d     = FILL;
            clr_col_d  = (COLS > 1) ? COL_BITS'(1) : '0;
            clr_row_d  = (COLS > 1) ? '0 : ROW_BITS'(1);
            clr_last_d = (COLS * ROWS == 1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (clean) begin
            state_q    <= S_READY;
            col_q      <= '0;
            row_q      <= '0;
            clr_col_q  <= '0;
            clr_row_q  <= '0;
            clr_last_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            clr_col_q  <= clr_col_d;
            clr_row_q  <= clr_row_d;
            clr_last_q <= clr_last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            full_q     <= full_d;
        end
    end

    assign o_ready   = !clean && ((state_q == S_READY) || (state_q == S_FULL));
    assign o_busy    = (state_q == S_CLR_ROW) || (state_q == S_CLR_SCR);
    assign o_we      = we_q;
    assign o_address = addr_q;
    assign o_data    = data_q;
    assign o_full    = full_q;
    assign o_col     = col_q;
    assign o_row     = row_q;

endmodule
